// File: rtl/bram_port_arbiter_pkg.sv
// Shared definitions for the BRAM port arbiter and the UART command path
// that drives its port A.
package bram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN_A = 2'd1,
        ST_OWN_B = 2'd2
    } arb_state_e;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 12;

    // UART command bytes understood by the port-A command path
    localparam logic [7:0] UART_CMD_READ  = 8'h11;
    localparam logic [7:0] UART_CMD_WRITE = 8'h12;
    localparam logic [7:0] UART_CMD_ERASE = 8'h13;
    localparam logic [7:0] UART_CMD_ESC   = 8'h1B;

    typedef struct packed {
        logic vld;
        logic id;
    } rd_tag_t;

endpackage

// File: rtl/bram_owner_watchdog.sv
// Counts consecutive idle cycles of the current BRAM owner and flags expiry
// on the edge where the count would reach TIMEOUT.
module bram_owner_watchdog
    import bram_port_arbiter_pkg::*;
#(
    parameter int TIMEOUT  = 1024,
    parameter int TO_WIDTH = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic clr_i,
    output logic expire_o
);

    localparam logic [TO_WIDTH-1:0] LIMIT = TO_WIDTH'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    logic [TO_WIDTH-1:0] cnt_q, cnt_d;

    // Expiry fires on the TIMEOUT-th idle edge; an accepted beat always wins.
    assign expire_o = (TIMEOUT > 0) && en_i && !clr_i && (cnt_q == LIMIT);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || !en_i || expire_o || (TIMEOUT == 0)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + TO_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Two-port round-robin arbiter with burst locking in front of a single-port
// BRAM; returns tagged read data and reclaims abandoned grants.
module bram_port_arbiter
    import bram_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = 1024,
    parameter int TO_WIDTH   = 11
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_a,
    input  logic                  req_b,
    input  logic                  we_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    input  logic                  last_a,
    input  logic                  last_b,
    output logic                  gnt_a,
    output logic                  gnt_b,
    output logic                  rvalid_a,
    output logic                  rvalid_b,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  timeout_err,
    input  logic [DATA_WIDTH-1:0] from_BRAM,
    output logic                  en,
    output logic                  write_enable,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] to_BRAM
);

    arb_state_e            state_q, state_d;
    logic                  rr_q, rr_d;
    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic                  to_err_q, to_err_d;
    rd_tag_t               rd0_q, rd0_d;
    rd_tag_t               rd1_q;

    logic                  own;
    logic                  owner_id;
    logic                  accept;
    logic                  sel_we;
    logic                  sel_last;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  wd_expire;

    assign own       = (state_q == ST_OWN_A) || (state_q == ST_OWN_B);
    assign owner_id  = (state_q == ST_OWN_B) ? PORT_B : PORT_A;
    assign accept    = ((state_q == ST_OWN_A) && req_a) || ((state_q == ST_OWN_B) && req_b);
    assign sel_we    = owner_id ? we_b    : we_a;
    assign sel_last  = owner_id ? last_b  : last_a;
    assign sel_addr  = owner_id ? addr_b  : addr_a;
    assign sel_wdata = owner_id ? wdata_b : wdata_a;

    bram_owner_watchdog #(
        .TIMEOUT  (TIMEOUT),
        .TO_WIDTH (TO_WIDTH)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .en_i     (own),
        .clr_i    (accept),
        .expire_o (wd_expire)
    );

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        en_d     = 1'b0;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdat_d   = wdat_q;
        to_err_d = 1'b0;
        rd0_d    = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (req_a && req_b) begin
                    state_d = (rr_q == PORT_A) ? ST_OWN_A : ST_OWN_B;
                end else if (req_a) begin
                    state_d = ST_OWN_A;
                end else if (req_b) begin
                    state_d = ST_OWN_B;
                end
            end
            ST_OWN_A, ST_OWN_B: begin
                if (accept) begin
                    en_d      = 1'b1;
                    we_d      = sel_we;
                    addr_d    = sel_addr;
                    wdat_d    = sel_wdata;
                    rd0_d.vld = !sel_we;
                    rd0_d.id  = owner_id;
                    if (sel_last) begin
                        state_d = ST_IDLE;
                        rr_d    = ~owner_id;
                    end
                end else if (wd_expire) begin
                    state_d  = ST_IDLE;
                    to_err_d = 1'b1;
                    rr_d     = ~owner_id;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // rd0 tracks the BRAM access cycle, rd1 the cycle its data is on from_BRAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_q     <= PORT_A;
            en_q     <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdat_q   <= '0;
            to_err_q <= 1'b0;
            rd0_q    <= '0;
            rd1_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdat_q   <= wdat_d;
            to_err_q <= to_err_d;
            rd0_q    <= rd0_d;
            rd1_q    <= rd0_q;
        end
    end

    assign gnt_a        = (state_q == ST_OWN_A);
    assign gnt_b        = (state_q == ST_OWN_B);
    assign rvalid_a     = rd1_q.vld && (rd1_q.id == PORT_A);
    assign rvalid_b     = rd1_q.vld && (rd1_q.id == PORT_B);
    assign rdata        = from_BRAM;
    assign timeout_err  = to_err_q;
    assign en           = en_q;
    assign write_enable = we_q;
    assign addr         = addr_q;
    assign to_BRAM      = wdat_q;

endmodule
